// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default bit timing for 12 MHz / 115200 baud and the
// receiver state encoding.
package uart_rx_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 104;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input; flops reset
// to RESET_VAL so an idle-high line reads as idle straight out of reset.
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a per-state cycle counter, one-cycle
// received / frame_error strobes, and a BREAK state so a held-low line errors once.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       received,
   output logic       frame_error,
   output logic       busy
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic rs;

   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rs)
   );

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             recv_q, recv_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      recv_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rs) state_d = START;
         end
         START: begin
            // Half a bit in: a line already back high was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rs) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = 3'd0;
               end
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rs, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            // Leave at mid stop bit so an immediately following start bit is seen.
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rs) begin
                  byte_d  = shift_q;
                  recv_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rs) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         byte_q  <= 8'h00;
         recv_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         recv_q  <= recv_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx_byte     = byte_q;
   assign received    = recv_q;
   assign frame_error = ferr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, strobes captured by a
// negedge monitor, results checked with immediate assertions.
module tb_uart_rx;

   localparam int   CPB       = 104;
   localparam int   SYNC      = 2;
   localparam int   HALF      = CPB / 2;
   localparam int   CPB_FAST  = 101;
   localparam int   CPB_SLOW  = 107;
   localparam logic [7:0] CMD_BYTE0 = 8'hB0;
   localparam logic [7:0] CMD_SET   = 8'h53;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_byte;
   logic       received;
   logic       frame_error;
   logic       busy;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         recv_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_t[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .rx_byte     (rx_byte),
      .received    (received),
      .frame_error (frame_error),
      .busy        (busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // monitor
   always @(negedge clk) begin
      if (received) begin
         recv_cnt++;
         got_q.push_back(rx_byte);
         got_t.push_back(cyc);
      end
      if (frame_error) ferr_cnt++;
      if (received && frame_error) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: compare captured bytes against the expected queue
   task automatic check_bytes(input string tag);
      logic [7:0] e;
      logic [7:0] o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         check(tag, {24'h0, o}, {24'h0, e});
      end
      check({tag, "_extra"}, got_q.size(), 0);
   endtask

   // drivers
   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input int bit_cyc, input logic stop_val);
      rx = 1'b0;
      repeat (bit_cyc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (bit_cyc) @(negedge clk);
      end
      rx = stop_val;
      repeat (bit_cyc) @(negedge clk);
   endtask

   initial begin
      int start_cyc;
      int base_recv;
      int base_ferr;

      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_rx_byte", rx_byte, 8'h00);
      check("reset_received", received, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      idle_bits(2);

      // single frame, exact baud, plus latency
      got_t.delete();
      exp_q.push_back(8'h55);
      start_cyc = cyc;
      send_frame(8'h55, CPB, 1'b1);
      check("f55_pulse_in_stop", recv_cnt, 1);
      check("f55_latency_ok", (got_t.size() == 1 && got_t[0] - start_cyc >= 990 &&
                              got_t[0] - start_cyc <= 992), 1);
      idle_bits(2);
      check_bytes("f55_byte");
      check("f55_rx_byte", rx_byte, 8'h55);
      check("f55_no_ferr", ferr_cnt, 0);
      check("f55_idle", busy, 0);

      // back-to-back frames
      got_t.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      send_frame(8'hA5, CPB, 1'b1);
      send_frame(8'h3C, CPB, 1'b1);
      idle_bits(2);
      check("b2b_count", recv_cnt, 3);
      check("b2b_gap", (got_t.size() == 2 && got_t[1] - got_t[0] >= 10 * CPB - 2 &&
                        got_t[1] - got_t[0] <= 10 * CPB + 2), 1);
      check_bytes("b2b_byte");
      check("b2b_rx_byte", rx_byte, 8'h3C);

      // start-bit glitch
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      check("glitch_busy_seen", busy, 1);
      repeat (HALF + SYNC + 2 - CPB / 4) @(negedge clk);
      check("glitch_busy_cleared", busy, 0);
      idle_bits(2);
      check("glitch_no_recv", recv_cnt, 3);
      check("glitch_no_ferr", ferr_cnt, 0);

      // framing error, then break, then recovery
      send_frame(8'h81, CPB, 1'b0);
      check("ferr_pulse", ferr_cnt, 1);
      check("ferr_no_recv", recv_cnt, 3);
      check("ferr_rx_byte_held", rx_byte, 8'h3C);
      rx = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      check("break_single_ferr", ferr_cnt, 1);
      check("break_busy", busy, 1);
      idle_bits(2);
      check("break_released", busy, 0);
      exp_q.push_back(8'h01);
      send_frame(8'h01, CPB, 1'b1);
      idle_bits(2);
      check_bytes("recover_byte");
      check("recover_rx_byte", rx_byte, 8'h01);

      // reset during data bit 4
      base_recv = recv_cnt;
      base_ferr = ferr_cnt;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB + HALF) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_rx_byte", rx_byte, 8'h00);
      check("midrst_received", received, 0);
      check("midrst_frame_error", frame_error, 0);
      check("midrst_busy", busy, 0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (CPB - HALF - 10 + 4 * CPB) @(negedge clk);
      check("midrst_no_recv", recv_cnt, base_recv);
      check("midrst_no_ferr", ferr_cnt, base_ferr);
      check("midrst_idle", busy, 0);
      idle_bits(1);
      exp_q.push_back(8'h12);
      send_frame(8'h12, CPB, 1'b1);
      idle_bits(2);
      check_bytes("post_rst_byte");
      check("post_rst_rx_byte", rx_byte, 8'h12);

      // command sequence at +3 % and -3 % baud
      base_recv = recv_cnt;
      exp_q.push_back(CMD_BYTE0);
      exp_q.push_back(8'hAA);
      exp_q.push_back(CMD_SET);
      send_frame(CMD_BYTE0, CPB_FAST, 1'b1);
      send_frame(8'hAA, CPB_FAST, 1'b1);
      send_frame(CMD_SET, CPB_FAST, 1'b1);
      idle_bits(2);
      check("fast_count", recv_cnt - base_recv, 3);
      check_bytes("fast_byte");

      base_recv = recv_cnt;
      exp_q.push_back(CMD_BYTE0);
      exp_q.push_back(8'hAA);
      exp_q.push_back(CMD_SET);
      send_frame(CMD_BYTE0, CPB_SLOW, 1'b1);
      send_frame(8'hAA, CPB_SLOW, 1'b1);
      send_frame(CMD_SET, CPB_SLOW, 1'b1);
      idle_bits(2);
      check("slow_count", recv_cnt - base_recv, 3);
      check_bytes("slow_byte");

      check("total_ferr", ferr_cnt, 1);
      check("strobes_exclusive", both_cnt, 0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
